id_ex_skid_reg: RTL
===================

Name: id_ex_skid_reg

Overview:
- Parametrised decode-to-execute pipeline register for the 5-stage RISC-V core.
- Replaces the free-running ID/EX register with a 2-entry skid buffer (main + skid) using a valid/ready handshake.
- Adds flush for branch-taken and load-use bubbles, plus a saturating bubble counter.
- Sits between the decode logic (control unit, register file, sign extend) and the execute stage.

Parameters:
XLEN, 32, width of operand, PC and immediate fields
REG_W, 5, register-address width
CTRL_W, 8, packed control bundle width {RegWrite, MemWrite, Branch, ALUSrc, ResultSrc[1:0], ALUControl[1:0]}; bundle is opaque to this block
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
valid_d  in  1  decode offers an instruction
ready_d  out  1  block can accept (registered)
rd1_d, rd2_d, pc_d, imm_d, pcplus4_d  in  XLEN each  operand/PC/immediate payload
rd_d, rs1_d, rs2_d  in  REG_W each  register addresses
ctrl_d  in  CTRL_W  control bundle
flush  in  1  kill all held and incoming entries
valid_e  out  1  execute-side entry valid
ready_e  in  1  execute consumes entry
rd1_e, rd2_e, pc_e, imm_e, pcplus4_e  out  XLEN each  registered payload
rd_e, rs1_e, rs2_e  out  REG_W each  registered addresses
ctrl_e  out  CTRL_W  registered control bundle
bubble_cnt  out  CNT_W  cycles with valid_e=0 since reset, saturating

Behaviour:
- Reset (rst=0, async): state EMPTY; main and skid payloads all 0; valid_e=0; ready_d=1; bubble_cnt=0.
- accept = valid_d & ready_d & ~flush; drain = valid_e & ready_e.
- Latency: accepted entry appears on *_e the next cycle when main was EMPTY or drains in that cycle.
- States:
  - EMPTY (main invalid)
  - BUSY (main valid, skid empty)
  - FULL (both valid)
- ready_d = (state != FULL), driven from a flop; no combinational path from ready_e.
- valid_e = (state != EMPTY); all *_e outputs driven directly from main flops.
- EMPTY:
  - accept -> BUSY, main <= input.
- BUSY:
  - accept & drain -> BUSY, main <= input.
  - accept & ~drain -> FULL, skid <= input.
  - ~accept & drain -> EMPTY.
  - Otherwise hold.
- FULL:
  - drain -> BUSY, main <= skid, skid cleared.
  - Otherwise hold.
  - No accept possible.
- flush has priority over everything:
  - Next state EMPTY; main and skid payloads cleared to 0.
  - Same-cycle input is dropped.
  - A same-cycle drain still completes (execute sees the entry this cycle).
- Whenever main becomes invalid (drain without refill), main payload is cleared to 0. ctrl_e=0 therefore implies a NOP (no RegWrite, MemWrite or Branch) when valid_e=0.
- Order is strict FIFO. Skid content is never overwritten while FULL. No entry is duplicated or lost except by flush.
- bubble_cnt increments on every cycle with valid_e=0 and saturates at all-ones.
- Reset mid-operation discards both entries immediately. ready_d returns to 1 asynchronously with reset assertion.
- The payload is not interpreted; widths are set only by the parameters.

Test Plan:
- Streaming: ready_e=1; valid_d=1 for 4 cycles with pc_d=0x00,0x04,0x08,0x0C -> pc_e shows the same sequence 1 cycle later, valid_e high 4 cycles, ready_d stays 1, bubble_cnt unchanged during the stream.
- Backpressure/skid: accept pc 0x10, then 0x14 while ready_e=0 -> state FULL, ready_d=0 the next cycle. Raise ready_e -> pc_e 0x10 then 0x14, no loss.
- Flush while FULL, with valid_d=1 pc 0x20 the same cycle -> next cycle valid_e=0, ctrl_e=0, pc_e=0, ready_d=1; 0x20 never appears.
- Drain to empty: single entry with ctrl_d=8'hA5 consumed -> next cycle valid_e=0, ctrl_e=8'h00, all *_e=0.
- Async reset asserted mid-FULL between clock edges -> valid_e=0, ready_d=1, bubble_cnt=0 immediately. After release with CNT_W=4 and idle for 20 cycles -> bubble_cnt=4'hF (saturated).

Source files
------------

// File: rtl/id_ex_skid_reg_if.sv
// Valid/ready handshake bundle carrying one decoded instruction between pipeline stages.
// The master drives valid and payload; the slave returns ready.
interface id_ex_skid_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [XLEN-1:0]   rd1, rd2, pc, imm, pcplus4;
    logic [REG_W-1:0]  rd, rs1, rs2;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid, rd1, rd2, pc, imm, pcplus4, rd, rs1, rs2, ctrl,
        input  ready
    );
    modport slave (
        input  valid, rd1, rd2, pc, imm, pcplus4, rd, rs1, rs2, ctrl,
        output ready
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register as a 2-entry skid buffer (main + skid) with flush
// and a saturating count of cycles with no valid entry toward execute.
module id_ex_skid_reg #(
    parameter int XLEN   = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_skid_reg_if.slave  dec,
    id_ex_skid_reg_if.master exe,
    input  logic             flush,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic [XLEN-1:0]   rd1, rd2, pc, imm, pcplus4;
        logic [REG_W-1:0]  rd, rs1, rs2;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t   state;
    payload_t main_q, skid_q, in_p;
    logic     ready_q;
    logic     accept, drain;

    assign in_p   = {dec.rd1, dec.rd2, dec.pc, dec.imm, dec.pcplus4,
                     dec.rd, dec.rs1, dec.rs2, dec.ctrl};
    assign accept = dec.valid & ready_q & ~flush;
    assign drain  = exe.valid & exe.ready;

    // Outputs come straight from flops; ready never depends on exe.ready.
    assign dec.ready   = ready_q;
    assign exe.valid   = (state != EMPTY);
    assign exe.rd1     = main_q.rd1;
    assign exe.rd2     = main_q.rd2;
    assign exe.pc      = main_q.pc;
    assign exe.imm     = main_q.imm;
    assign exe.pcplus4 = main_q.pcplus4;
    assign exe.rd      = main_q.rd;
    assign exe.rs1     = main_q.rs1;
    assign exe.rs2     = main_q.rs2;
    assign exe.ctrl    = main_q.ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            ready_q    <= 1'b1;
            bubble_cnt <= '0;
        end else begin
            if (state == EMPTY && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);

            if (flush) begin
                state   <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q <= in_p;
                            state  <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (accept && drain) begin
                            main_q <= in_p;
                        end else if (accept) begin
                            skid_q  <= in_p;
                            state   <= FULL;
                            ready_q <= 1'b0;
                        end else if (drain) begin
                            // Cleared payload makes an invalid slot look like a NOP.
                            main_q <= '0;
                            state  <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            main_q  <= skid_q;
                            skid_q  <= '0;
                            state   <= BUSY;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
